// File: rtl/avst_decim_arbiter.sv
// -----------------------------------------------------------------------------
// avst_decim_arbiter
//
// Two-requester Avalon-ST packet arbiter that fronts a shared decimator.
// For every packet it grants one sink (round-robin on contention), programs
// the decimator with that requester's decimation factor through a one-cycle
// CSR write, then forwards the packet combinationally to the source port until
// the accepted eop beat.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   csr_*               : host register port (64-bit, byte-enable qualified
//                         writes, combinational read gated by csr_read)
//                         [0] enable, [1] last_grant, [31:16] factor0,
//                         [47:32] factor1, [63:48] pkt_count
//   snk0_*, snk1_*      : Avalon-ST sinks, one per requester
//   src_*               : Avalon-ST source towards the decimator
//   dcsr_*              : CSR write master towards the decimator
// -----------------------------------------------------------------------------
module avst_decim_arbiter #(
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   csr_write,
  input  logic [63:0]            csr_writedata,
  input  logic [7:0]             csr_byteenable,
  input  logic                   csr_read,
  output logic [63:0]            csr_readdata,

  input  logic [DATA_WIDTH-1:0]  snk0_data,
  input  logic                   snk0_valid,
  output logic                   snk0_ready,
  input  logic                   snk0_sop,
  input  logic                   snk0_eop,
  input  logic [EMPTY_WIDTH-1:0] snk0_empty,

  input  logic [DATA_WIDTH-1:0]  snk1_data,
  input  logic                   snk1_valid,
  output logic                   snk1_ready,
  input  logic                   snk1_sop,
  input  logic                   snk1_eop,
  input  logic [EMPTY_WIDTH-1:0] snk1_empty,

  output logic [DATA_WIDTH-1:0]  src_data,
  output logic                   src_valid,
  input  logic                   src_ready,
  output logic                   src_sop,
  output logic                   src_eop,
  output logic [EMPTY_WIDTH-1:0] src_empty,

  output logic                   dcsr_write,
  output logic [63:0]            dcsr_writedata,
  output logic [7:0]             dcsr_byteenable
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONFIG = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Only enable and the two factors are host-writable; everything else in the
  // stored register stays zero so it can be OR-ed with the RO fields on read.
  localparam logic [63:0] HOST_WRITABLE = 64'h0000_FFFF_FFFF_0001;

  // Expand a byte-enable vector into a per-bit write mask.
  function automatic logic [63:0] be_expand(input logic [7:0] be);
    logic [63:0] mask;
    mask = 64'h0;
    for (int i = 0; i < 8; i++) begin
      mask[i*8 +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

  state_t                   state_r, state_next_s;
  logic                     grant_r, grant_next_s;
  logic                     last_grant_r, last_grant_next_s;
  logic [15:0]              pkt_count_r, pkt_count_next_s;
  logic [63:0]              host_reg_r, host_reg_next_s;
  logic [63:0]              wr_mask_s;

  logic                     enable_s;
  logic [15:0]              factor0_s, factor1_s, factor_g_s;

  logic [DATA_WIDTH-1:0]    sel_data_s;
  logic                     sel_valid_s, sel_sop_s, sel_eop_s;
  logic [EMPTY_WIDTH-1:0]   sel_empty_s;

  assign enable_s   = host_reg_r[0];
  assign factor0_s  = host_reg_r[31:16];
  assign factor1_s  = host_reg_r[47:32];
  assign factor_g_s = grant_r ? factor1_s : factor0_s;

  // Granted sink as seen by the source port.
  assign sel_data_s  = grant_r ? snk1_data  : snk0_data;
  assign sel_valid_s = grant_r ? snk1_valid : snk0_valid;
  assign sel_sop_s   = grant_r ? snk1_sop   : snk0_sop;
  assign sel_eop_s   = grant_r ? snk1_eop   : snk0_eop;
  assign sel_empty_s = grant_r ? snk1_empty : snk0_empty;

  assign wr_mask_s = be_expand(csr_byteenable) & HOST_WRITABLE;

  // Host register update: byte-enable qualified merge into writable bits only.
  always_comb begin
    host_reg_next_s = host_reg_r;
    if (csr_write) begin
      host_reg_next_s = (host_reg_r & ~wr_mask_s) | (csr_writedata & wr_mask_s);
    end else begin
      host_reg_next_s = host_reg_r;
    end
  end

  // Host read mux: stored R/W fields combined with the live RO fields.
  always_comb begin
    if (csr_read) begin
      csr_readdata = host_reg_r | {pkt_count_r, 32'h0, 14'h0, last_grant_r, 1'b0};
    end else begin
      csr_readdata = 64'h0;
    end
  end

  // Arbitration FSM: next state, grant bookkeeping and all datapath outputs.
  always_comb begin
    state_next_s      = state_r;
    grant_next_s      = grant_r;
    last_grant_next_s = last_grant_r;
    pkt_count_next_s  = pkt_count_r;
    src_data          = {DATA_WIDTH{1'b0}};
    src_valid         = 1'b0;
    src_sop           = 1'b0;
    src_eop           = 1'b0;
    src_empty         = {EMPTY_WIDTH{1'b0}};
    snk0_ready        = 1'b0;
    snk1_ready        = 1'b0;
    dcsr_write        = 1'b0;
    dcsr_writedata    = 64'h0;
    dcsr_byteenable   = 8'h0;

    case (state_r)
      ST_IDLE: begin
        if (enable_s && (snk0_valid || snk1_valid)) begin
          // Contention goes to whoever was not served last.
          if (snk0_valid && snk1_valid) begin
            grant_next_s = ~last_grant_r;
          end else begin
            grant_next_s = snk1_valid;
          end
          state_next_s = ST_CONFIG;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_CONFIG: begin
        // Enable the decimator, clear its counter, load the granted factor.
        dcsr_write        = 1'b1;
        dcsr_byteenable   = 8'h3F;
        dcsr_writedata    = {16'h0, 16'h0, factor_g_s, 15'h0, 1'b1};
        last_grant_next_s = grant_r;
        state_next_s      = ST_STREAM;
      end

      ST_STREAM: begin
        src_data  = sel_data_s;
        src_valid = sel_valid_s;
        src_sop   = sel_sop_s;
        src_eop   = sel_eop_s;
        src_empty = sel_empty_s;
        if (grant_r) begin
          snk1_ready = src_ready;
        end else begin
          snk0_ready = src_ready;
        end
        // Enable is deliberately not consulted here so packets never truncate.
        if (sel_valid_s && src_ready && sel_eop_s) begin
          pkt_count_next_s = pkt_count_r + 16'd1;
          state_next_s     = ST_IDLE;
        end else begin
          state_next_s     = ST_STREAM;
        end
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b0;
      pkt_count_r  <= 16'h0;
      host_reg_r   <= 64'h0;
    end else begin
      state_r      <= state_next_s;
      grant_r      <= grant_next_s;
      last_grant_r <= last_grant_next_s;
      pkt_count_r  <= pkt_count_next_s;
      host_reg_r   <= host_reg_next_s;
    end
  end

endmodule
